// File: rtl/veririsc_pkg.sv
//==============================================================================
// Module : veririsc_pkg
// Brief  : Shared opcode, phase and sequencer-state definitions for the
//          instruction-cycle controller. Honours macro PHASE_SEQ_STEP_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package veririsc_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OPC_W  = 3;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 16;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  localparam logic [2:0] PH_0 = 3'd0;
  localparam logic [2:0] PH_1 = 3'd1;
  localparam logic [2:0] PH_2 = 3'd2;
  localparam logic [2:0] PH_3 = 3'd3;
  localparam logic [2:0] PH_4 = 3'd4;
  localparam logic [2:0] PH_5 = 3'd5;
  localparam logic [2:0] PH_6 = 3'd6;
  localparam logic [2:0] PH_7 = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
`ifdef PHASE_SEQ_STEP_EN
    ST_PAUSED = 2'd2,
`endif
    ST_HALTED = 2'd1
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/seq_phase_counter.sv
//==============================================================================
// Module : seq_phase_counter
// Brief  : 3-bit phase counter with enable and synchronous clear.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_phase_counter
  import veririsc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] count
);

  logic [2:0] r_count;

  // Clear has priority so a halt lands on phase 0 regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= PH_0;
    end else if (clr) begin
      r_count <= PH_0;
    end else if (en) begin
      r_count <= r_count + 3'd1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
//==============================================================================
// Module : phase_sequencer
// Brief  : Phase generator, instruction register and run/halt control for the
//          instruction-cycle controller. Optional single-step via
//          PHASE_SEQ_STEP_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module phase_sequencer
  import veririsc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              resume,
  input  logic              ld_ir,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] ac_in,
`ifdef PHASE_SEQ_STEP_EN
  input  logic              step_mode,
  input  logic              step_req,
`endif
  output logic [2:0]        phase,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              zero,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  seq_state_e        r_state;
  logic              r_halted;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_ir;
  logic              r_zero;
  logic [2:0]        w_phase;
  logic              w_running;
  logic              w_halt_take;

  assign w_running   = (r_state == ST_RUN);
  assign w_halt_take = w_running && halt;

  seq_phase_counter u_phase_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_running && !halt),
    .clr   (w_halt_take),
    .count (w_phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (w_phase == PH_7) begin
            if (r_count != c_cnt_max) begin
              r_count <= r_count + CNT_W'(1);
            end
`ifdef PHASE_SEQ_STEP_EN
            if (step_mode) begin
              r_state <= ST_PAUSED;
            end
`endif
          end
        end
        ST_HALTED: begin
          // halt wins over a coincident resume
          if (resume && !halt) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
`ifdef PHASE_SEQ_STEP_EN
        ST_PAUSED: begin
          // staying in step mode re-pauses at the next wrap, giving one instruction
          if (step_req || !step_mode) begin
            r_state <= ST_RUN;
          end
        end
`endif
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir   <= '0;
      r_zero <= 1'b0;
    end else begin
      if (ld_ir) begin
        r_ir <= data_in;
      end
      r_zero <= (ac_in == '0);
    end
  end

  assign phase       = w_phase;
  assign opcode      = r_ir[DATA_W-1 -: OPC_W];
  assign ir_addr     = r_ir[ADDR_W-1:0];
  assign zero        = r_zero;
  assign halted      = r_halted;
  assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
//==============================================================================
// Module : tb_phase_sequencer
// Brief  : Self-checking bench for phase_sequencer (PHASE_SEQ_STEP_EN aware).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_phase_sequencer;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 3;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              halt = 1'b0;
  logic              resume = 1'b0;
  logic              ld_ir = 1'b0;
  logic              step_mode = 1'b0;
  logic              step_req = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] ac_in = 8'h10;
  logic [2:0]        phase;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              zero;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;

  always #5 clk = ~clk;

  phase_sequencer #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .resume      (resume),
    .ld_ir       (ld_ir),
    .data_in     (data_in),
    .ac_in       (ac_in),
`ifdef PHASE_SEQ_STEP_EN
    .step_mode   (step_mode),
    .step_req    (step_req),
`endif
    .phase       (phase),
    .opcode      (opcode),
    .ir_addr     (ir_addr),
    .zero        (zero),
    .halted      (halted),
    .instr_count (instr_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: run/halt/pause flags plus plain integer phase and count.
  int   m_phase;
  int   m_count;
  bit   m_halted;
  bit   m_paused;
  bit   m_zero;
  logic [DATA_W-1:0] m_ir;

  typedef struct {
    logic              ld;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] a;
    int                ph;
    int                opc;
    int                addr;
    int                z;
    int                cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_count  = 0;
    m_halted = 0;
    m_paused = 0;
    m_zero   = 0;
    m_ir     = '0;
  endtask

  task automatic model_edge();
    if (ld_ir) m_ir = data_in;
    m_zero = (ac_in == 0);
    if (m_halted) begin
      if (resume && !halt) m_halted = 0;
    end else if (m_paused) begin
      if (step_req || !step_mode) m_paused = 0;
    end else if (halt) begin
      m_halted = 1;
      m_phase  = 0;
    end else begin
      if (m_phase == 7) begin
        m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
`ifdef PHASE_SEQ_STEP_EN
        if (step_mode) m_paused = 1;
`endif
      end
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".phase"},  32'(phase),       32'(m_phase));
    check({tag, ".halted"}, 32'(halted),      32'(m_halted));
    check({tag, ".opcode"}, 32'(opcode),      32'(m_ir[DATA_W-1 -: OPC_W]));
    check({tag, ".addr"},   32'(ir_addr),     32'(m_ir[ADDR_W-1:0]));
    check({tag, ".zero"},   32'(zero),        32'(m_zero));
    check({tag, ".count"},  32'(instr_count), 32'(m_count));
  endtask

  task automatic tick(input logic h, input logic r, input logic l,
                      input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] a);
    halt    = h;
    resume  = r;
    ld_ir   = l;
    data_in = d;
    ac_in   = a;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("model");
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 8'h00, 8'h10);
  endtask

  task automatic run_to_phase(input int p);
    for (int i = 0; i < 16 && m_phase != p; i++) idle();
    check("run_to_phase", 32'(phase), 32'(p));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    halt = 0; resume = 0; ld_ir = 0; step_mode = 0; step_req = 0;
    #2;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 8'h10, 1, 0, 0,    0, 0};
    tbl[1]  = '{1'b0, 8'h00, 8'h10, 2, 0, 0,    0, 0};
    tbl[2]  = '{1'b1, 8'hE5, 8'h10, 3, 7, 5,    0, 0};
    tbl[3]  = '{1'b1, 8'hE5, 8'h10, 4, 7, 5,    0, 0};
    tbl[4]  = '{1'b0, 8'h00, 8'h10, 5, 7, 5,    0, 0};
    tbl[5]  = '{1'b0, 8'h00, 8'h00, 6, 7, 5,    1, 0};
    tbl[6]  = '{1'b0, 8'h00, 8'h01, 7, 7, 5,    0, 0};
    tbl[7]  = '{1'b0, 8'h00, 8'h10, 0, 7, 5,    0, 1};
    tbl[8]  = '{1'b0, 8'h00, 8'h10, 1, 7, 5,    0, 1};
    tbl[9]  = '{1'b0, 8'h00, 8'h10, 2, 7, 5,    0, 1};
    tbl[10] = '{1'b1, 8'h4A, 8'h10, 3, 2, 'hA,  0, 1};
    tbl[11] = '{1'b0, 8'h00, 8'h10, 4, 2, 'hA,  0, 1};
    tbl[12] = '{1'b0, 8'h00, 8'h00, 5, 2, 'hA,  1, 1};
    tbl[13] = '{1'b0, 8'h00, 8'h00, 6, 2, 'hA,  1, 1};
    tbl[14] = '{1'b0, 8'h00, 8'hFF, 7, 2, 'hA,  0, 1};
    tbl[15] = '{1'b0, 8'h00, 8'h10, 0, 2, 'hA,  0, 2};

    #1;
    do_reset();

    // Vector table: two full instructions, IR loads and zero-flag lag
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, tbl[i].ld, tbl[i].d, tbl[i].a);
      check("tbl.phase",  32'(phase),       32'(tbl[i].ph));
      check("tbl.opcode", 32'(opcode),      32'(tbl[i].opc));
      check("tbl.addr",   32'(ir_addr),     32'(tbl[i].addr));
      check("tbl.zero",   32'(zero),        32'(tbl[i].z));
      check("tbl.count",  32'(instr_count), 32'(tbl[i].cnt));
      check("tbl.halted", 32'(halted),      32'd0);
    end

    // Halt at phase 4, hold for 10 cycles, then resume
    run_to_phase(4);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h10);
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.phase",  32'(phase),  32'd0);
    check("halt.count",  32'(instr_count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("halt.hold", 32'(phase), 32'd0);
    end
    check("halt.count_held", 32'(instr_count), 32'd2);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 8'h10);
    check("resume.halted", 32'(halted), 32'd0);
    check("resume.phase0", 32'(phase),  32'd0);
    idle();
    check("resume.phase1", 32'(phase), 32'd1);
    idle();
    check("resume.phase2", 32'(phase), 32'd2);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 8'h10);
    check("resume_in_run", 32'(phase), 32'd3);

    // Simultaneous halt and resume: halt wins
    run_to_phase(4);
    tick(1'b1, 1'b1, 1'b0, 8'h00, 8'h10);
    check("halt_resume.halted", 32'(halted), 32'd1);
    tick(1'b1, 1'b1, 1'b0, 8'h00, 8'h10);
    check("halt_resume.stay", 32'(halted), 32'd1);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 8'h10);
    check("halt_resume.leave", 32'(halted), 32'd0);

    // Asynchronous reset mid-instruction, checked before the next edge
    tick(1'b0, 1'b0, 1'b1, 8'hFF, 8'h10);
    run_to_phase(5);
    rst_n = 1'b0;
    #2;
    check("async.phase",  32'(phase),       32'd0);
    check("async.opcode", 32'(opcode),      32'd0);
    check("async.count",  32'(instr_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation with CNT_W = 4
    for (int i = 0; i < CMAX * 8 + 16; i++) idle();
    check("sat.count", 32'(instr_count), 32'(CMAX));
    check("sat.phase", 32'(phase), 32'd0);

    // Randomised run against the model
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), DATA_W'($urandom),
           ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom));
    end

`ifdef PHASE_SEQ_STEP_EN
    @(posedge clk);
    #1;
    do_reset();
    step_mode = 1'b1;
    for (int i = 0; i < 8; i++) idle();
    check("step.pause_phase", 32'(phase), 32'd0);
    check("step.pause_count", 32'(instr_count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("step.paused_hold", 32'(phase), 32'd0);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 8'h10);
    check("step.resume_ignored", 32'(phase), 32'd0);
    idle();
    check("step.still_paused", 32'(phase), 32'd0);
    step_req = 1'b1;
    idle();
    step_req = 1'b0;
    check("step.req_phase", 32'(phase), 32'd0);
    for (int i = 0; i < 8; i++) begin
      idle();
      check("step.seq", 32'(phase), 32'((i + 1) % 8));
    end
    check("step.count", 32'(instr_count), 32'd2);
    idle();
    check("step.repaused", 32'(phase), 32'd0);
    step_mode = 1'b0;
    idle();
    idle();
    check("step.free_run", 32'(phase), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
